// File: rtl/pipe_defs_pkg.sv
// Shared definitions for the memory-stage engine.
//  - MEM_OP_*  : encodings of the mem_op field carried by the EX/MEM register
//  - state_t   : memory-stage controller states
//  - REG_ZERO  : hard-wired zero register; writes to it are suppressed
package pipe_defs_pkg;

   localparam logic [1:0] MEM_OP_NONE  = 2'b00;
   localparam logic [1:0] MEM_OP_LOAD  = 2'b01;
   localparam logic [1:0] MEM_OP_STORE = 2'b10;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_t;

   localparam int unsigned REG_ZERO = 0;

   // 2'b11 is reserved and behaves like MEM_OP_NONE
   function automatic logic is_mem_op(input logic [1:0] op);
      return (op == MEM_OP_LOAD) || (op == MEM_OP_STORE);
   endfunction

endpackage

// File: rtl/pipe_mem_timeout.sv
// Wait counter for an outstanding data-memory access.
//  clk     in  clock
//  reset   in  synchronous active-low reset
//  clear   in  restart counting from 0
//  enable  in  one more cycle waited without an ack
//  expired out this enabled cycle brings the count to TIMEOUT_CYCLES
module pipe_mem_timeout
   import pipe_defs_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (!reset)      count <= '0;
      else if (clear)  count <= '0;
      else if (enable) count <= count + 1'b1;
   end

   // Flag the cycle whose increment would reach the limit, so the access
   // is retired exactly after TIMEOUT_CYCLES request cycles.
   assign expired = enable && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/pipe_mem_access.sv
// Memory-stage engine between the EX/MEM register and writeback.
// ALU-only ops complete in one cycle; loads/stores are captured and issued to
// a variable-latency data memory over a req/ack handshake, stalling upstream.
//  clk, reset          clock / synchronous active-low reset
//  valid_in .. mem_op_in  EX/MEM register contents
//  stall_out           upstream register enable = ~stall_out
//  dmem_*              data memory request/response
//  valid_out .. wb_en_out writeback outputs (valid_out/wb_en_out are pulses)
//  mem_err_out         sticky access-timeout flag
module pipe_mem_access
   import pipe_defs_pkg::*;
#(
   parameter int DATAPATH_WIDTH     = 64,
   parameter int REGFILE_ADDR_WIDTH = 5,
   parameter int INST_ADDR_WIDTH    = 9,
   parameter int DMEM_ADDR_WIDTH    = 8,
   parameter int TIMEOUT_CYCLES     = 255
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          valid_in,
   input  logic [INST_ADDR_WIDTH-1:0]    pc_in,
   input  logic [DATAPATH_WIDTH-1:0]     accum_in,
   input  logic [DATAPATH_WIDTH-1:0]     store_data_in,
   input  logic [REGFILE_ADDR_WIDTH-1:0] WR_addr_in,
   input  logic [1:0]                    mem_op_in,
   output logic                          stall_out,
   output logic                          dmem_req,
   output logic                          dmem_we,
   output logic [DMEM_ADDR_WIDTH-1:0]    dmem_addr,
   output logic [DATAPATH_WIDTH-1:0]     dmem_wdata,
   input  logic [DATAPATH_WIDTH-1:0]     dmem_rdata,
   input  logic                          dmem_ack,
   output logic                          valid_out,
   output logic [INST_ADDR_WIDTH-1:0]    pc_out,
   output logic [DATAPATH_WIDTH-1:0]     wb_data_out,
   output logic [REGFILE_ADDR_WIDTH-1:0] WR_addr_out,
   output logic                          wb_en_out,
   output logic                          mem_err_out
);

   localparam logic [REGFILE_ADDR_WIDTH-1:0] REG_Z = REGFILE_ADDR_WIDTH'(REG_ZERO);

   state_t state, state_nxt;

   logic [INST_ADDR_WIDTH-1:0]    pc_q;
   logic [REGFILE_ADDR_WIDTH-1:0] wr_q;
   logic [1:0]                    op_q;
   logic [DMEM_ADDR_WIDTH-1:0]    addr_q;
   logic [DATAPATH_WIDTH-1:0]     wdata_q;

   logic mem_start;
   logic expired;
   logic done;

   // Only the low address bits index the data memory.
   logic unused_accum_hi;
   assign unused_accum_hi = ^accum_in[DATAPATH_WIDTH-1:DMEM_ADDR_WIDTH];

   assign mem_start = valid_in && is_mem_op(mem_op_in);
   // An access retires on ack or on timeout; ack in the expiry cycle wins
   // because the counter is not enabled when ack is present.
   assign done      = dmem_ack || expired;

   pipe_mem_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .clear  (state == ST_IDLE),
      .enable ((state == ST_ACCESS) && !dmem_ack),
      .expired(expired)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next state
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (mem_start) state_nxt = ST_ACCESS;
         ST_ACCESS: if (done)      state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Outputs. The upstream register is released in the retiring cycle
   // (ack or timeout) so the next instruction lines up for the following cycle.
   always_comb begin
      stall_out = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      case (state)
         ST_IDLE: stall_out = mem_start;
         ST_ACCESS: begin
            stall_out = !done;
            dmem_req  = 1'b1;
            dmem_we   = (op_q == MEM_OP_STORE);
         end
         default: ;
      endcase
   end

   assign dmem_addr  = addr_q;
   assign dmem_wdata = wdata_q;

   // Request capture and writeback registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_q        <= '0;
         wr_q        <= '0;
         op_q        <= MEM_OP_NONE;
         addr_q      <= '0;
         wdata_q     <= '0;
         valid_out   <= 1'b0;
         pc_out      <= '0;
         wb_data_out <= '0;
         WR_addr_out <= '0;
         wb_en_out   <= 1'b0;
         mem_err_out <= 1'b0;
      end else begin
         valid_out <= 1'b0;
         wb_en_out <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (mem_start) begin
                  pc_q    <= pc_in;
                  wr_q    <= WR_addr_in;
                  op_q    <= mem_op_in;
                  addr_q  <= accum_in[DMEM_ADDR_WIDTH-1:0];
                  wdata_q <= store_data_in;
               end else if (valid_in) begin
                  valid_out   <= 1'b1;
                  pc_out      <= pc_in;
                  wb_data_out <= accum_in;
                  WR_addr_out <= WR_addr_in;
                  wb_en_out   <= (WR_addr_in != REG_Z);
               end
            end
            ST_ACCESS: begin
               if (done) begin
                  valid_out   <= 1'b1;
                  pc_out      <= pc_q;
                  WR_addr_out <= wr_q;
                  if (dmem_ack && (op_q == MEM_OP_LOAD)) begin
                     wb_data_out <= dmem_rdata;
                     wb_en_out   <= (wr_q != REG_Z);
                  end else begin
                     wb_data_out <= '0;
                  end
                  if (!dmem_ack) mem_err_out <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_mem_access.sv
module tb_pipe_mem_access;
   localparam int DW = 64, RW = 5, IW = 9, AW = 8, TO = 4;

   logic          clk = 1'b0, reset = 1'b0;
   logic          valid_in = 1'b0;
   logic [IW-1:0] pc_in = '0;
   logic [DW-1:0] accum_in = '0, store_data_in = '0, dmem_rdata = '0;
   logic [RW-1:0] WR_addr_in = '0;
   logic [1:0]    mem_op_in = '0;
   logic          dmem_ack = 1'b0;
   logic          stall_out, dmem_req, dmem_we, valid_out, wb_en_out, mem_err_out;
   logic [AW-1:0] dmem_addr;
   logic [DW-1:0] dmem_wdata, wb_data_out;
   logic [IW-1:0] pc_out;
   logic [RW-1:0] WR_addr_out;

   always #5 clk = ~clk;

   pipe_mem_access #(.DATAPATH_WIDTH(DW), .REGFILE_ADDR_WIDTH(RW), .INST_ADDR_WIDTH(IW),
                     .DMEM_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .valid_in(valid_in), .pc_in(pc_in), .accum_in(accum_in),
      .store_data_in(store_data_in), .WR_addr_in(WR_addr_in), .mem_op_in(mem_op_in),
      .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
      .valid_out(valid_out), .pc_out(pc_out), .wb_data_out(wb_data_out),
      .WR_addr_out(WR_addr_out), .wb_en_out(wb_en_out), .mem_err_out(mem_err_out));

   // dly: index of the request cycle in which memory acks (>= TO means never)
   typedef struct {
      logic v; logic [1:0] op; logic [IW-1:0] pc; logic [DW-1:0] accum, sd, rdat;
      logic [RW-1:0] wr; int dly;
   } instr_t;
   typedef struct {
      logic [IW-1:0] pc; logic [DW-1:0] data; logic [RW-1:0] wr; logic en; logic chk_data;
   } wb_t;

   instr_t iq[$];
   wb_t    exp_q[$];
   logic [DW-1:0] wb_log[$];
   logic          en_log[$];
   int checks = 0, errors = 0;
   logic err_exp = 1'b0, started = 1'b0;

   // model state: upstream instruction presented, and the access in flight
   instr_t pres, cur;
   logic   busy = 1'b0, hold = 1'b0, force_stray = 1'b0;
   int     w = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic is_mem(input logic [1:0] op);
      return op == 2'b01 || op == 2'b10;
   endfunction

   // compare process: writeback stream and error flag against the model
   always @(posedge clk) begin
      wb_t e;
      #1;
      if (started) begin
         chk("mem_err_out", mem_err_out, err_exp);
         if (valid_out) begin
            if (exp_q.size() == 0) chk("valid_out with nothing expected", valid_out, 0);
            else begin
               e = exp_q.pop_front();
               chk("pc_out", pc_out, e.pc);
               chk("WR_addr_out", WR_addr_out, e.wr);
               chk("wb_en_out", wb_en_out, e.en);
               if (e.chk_data) chk("wb_data_out", wb_data_out, e.data);
               wb_log.push_back(wb_data_out);
               en_log.push_back(wb_en_out);
            end
         end else chk("wb_en_out without valid_out", wb_en_out, 0);
      end
   end

   // one cycle of upstream register + memory responder, called at negedge
   task automatic drive_cycle();
      logic ack, exp_stall, was_busy;
      logic [DW-1:0] rd;
      if (!hold) begin
         if (iq.size() != 0) pres = iq.pop_front();
         else begin
            pres.v = 1'b0; pres.op = 2'(($urandom_range(0, 3)));
            pres.pc = IW'($urandom); pres.accum = {$urandom, $urandom};
         end
      end
      valid_in = pres.v; mem_op_in = pres.op; pc_in = pres.pc; accum_in = pres.accum;
      store_data_in = pres.sd; WR_addr_in = pres.wr;
      was_busy = busy;
      rd = busy ? cur.rdat : {$urandom, $urandom};
      ack = busy ? (w == cur.dly) : (force_stray || $urandom_range(0, 7) == 0);
      dmem_ack = ack; dmem_rdata = rd;
      if (!busy) begin
         if (pres.v && is_mem(pres.op)) begin
            busy = 1'b1; w = 0; cur = pres; exp_stall = 1'b1;
         end else begin
            exp_stall = 1'b0;
            if (pres.v) exp_q.push_back('{pc: pres.pc, data: pres.accum, wr: pres.wr,
                                          en: (pres.wr != 0), chk_data: 1'b1});
         end
      end else if (ack) begin
         exp_q.push_back('{pc: cur.pc, data: (cur.op == 2'b01) ? rd : '0, wr: cur.wr,
                           en: (cur.op == 2'b01) && (cur.wr != 0), chk_data: 1'b1});
         busy = 1'b0; exp_stall = 1'b0;
      end else if (w + 1 == TO) begin
         exp_q.push_back('{pc: cur.pc, data: '0, wr: cur.wr, en: 1'b0, chk_data: 1'b0});
         err_exp = 1'b1; busy = 1'b0; exp_stall = 1'b0;
      end else begin
         w++; exp_stall = 1'b1;
      end
      #1;
      chk("stall_out", stall_out, exp_stall);
      chk("dmem_req", dmem_req, was_busy);
      if (was_busy) begin
         chk("dmem_we", dmem_we, cur.op == 2'b10);
         chk("dmem_addr", dmem_addr, cur.accum[AW-1:0]);
         chk("dmem_wdata", dmem_wdata, cur.sd);
      end
      hold = exp_stall;
   endtask

   task automatic drain();
      int n = 0;
      while ((iq.size() != 0 || busy || hold) && n < 5000) begin
         @(negedge clk); drive_cycle(); n++;
      end
      chk("drain within cycle budget", n < 5000, 1);
      repeat (2) begin @(negedge clk); drive_cycle(); end
      chk("model queue empty", exp_q.size(), 0);
   endtask

   function automatic instr_t mk(input logic [1:0] op, input int pc, input logic [DW-1:0] acc,
                                 input logic [DW-1:0] sd, input int wr, input int dly,
                                 input logic [DW-1:0] rdat);
      instr_t i;
      i.v = 1'b1; i.op = op; i.pc = IW'(pc); i.accum = acc; i.sd = sd;
      i.wr = RW'(wr); i.dly = dly; i.rdat = rdat;
      return i;
   endfunction

   initial begin
      pres = mk(2'b00, 0, '0, '0, 0, 0, '0); pres.v = 1'b0;
      cur = pres;
      repeat (2) @(negedge clk);
      started = 1'b1;
      chk("reset valid_out", valid_out, 0);
      chk("reset dmem_req", dmem_req, 0);
      chk("reset wb_data_out", wb_data_out, 0);
      chk("reset pc_out", pc_out, 0);
      reset = 1'b1;

      // directed sequence
      iq.push_back(mk(2'b00, 1, 64'h1234, 64'h0, 5, 0, 64'h0));
      iq.push_back(mk(2'b01, 2, 64'h42, 64'h0, 7, 2, 64'hDEAD));
      iq.push_back(mk(2'b10, 3, 64'h10, 64'hBEEF, 9, 0, 64'h0));
      iq.push_back(mk(2'b01, 4, 64'h20, 64'h0, 0, 1, 64'h55));
      iq.push_back(mk(2'b01, 5, 64'h30, 64'h0, 3, 9, 64'h66));
      iq.push_back(mk(2'b00, 6, 64'h77, 64'h0, 2, 0, 64'h0));
      iq.push_back(mk(2'b01, 7, 64'h31, 64'h0, 1, 0, 64'hA1));
      iq.push_back(mk(2'b01, 8, 64'h32, 64'h0, 2, 3, 64'hA2));
      iq.push_back(mk(2'b11, 9, 64'hA3, 64'h0, 3, 0, 64'h0));
      drain();

      // literal expectations of the directed writeback stream
      chk("directed count", wb_log.size(), 9);
      if (wb_log.size() == 9) begin
         chk("lit alu data", wb_log[0], 64'h1234);
         chk("lit load data", wb_log[1], 64'hDEAD);
         chk("lit store data", wb_log[2], 64'h0);
         chk("lit load r0 data", wb_log[3], 64'h55);
         chk("lit alu2 data", wb_log[5], 64'h77);
         chk("lit b2b data", {wb_log[6][7:0], wb_log[7][7:0], wb_log[8][7:0]}, 24'hA1A2A3);
         chk("lit wb_en pattern", {en_log[0], en_log[1], en_log[2], en_log[3], en_log[4],
                                   en_log[5], en_log[6], en_log[7], en_log[8]}, 9'b110001111);
      end
      chk("lit mem_err sticky", mem_err_out, 1);

      // reset in the middle of an access
      iq.push_back(mk(2'b01, 20, 64'h99, 64'h0, 4, 9, 64'h0));
      repeat (3) begin @(negedge clk); drive_cycle(); end
      chk("access in flight before reset", dmem_req, 1);
      @(negedge clk);
      reset = 1'b0; valid_in = 1'b0; dmem_ack = 1'b1;
      busy = 1'b0; hold = 1'b0; err_exp = 1'b0;
      @(negedge clk);
      chk("rst dmem_req", dmem_req, 0);
      chk("rst valid_out", valid_out, 0);
      chk("rst mem_err_out", mem_err_out, 0);
      chk("rst stall_out", stall_out, 0);
      chk("rst wb_outs", {pc_out, WR_addr_out, wb_en_out, dmem_we}, 0);
      reset = 1'b1;
      force_stray = 1'b1;
      repeat (3) begin @(negedge clk); drive_cycle(); end
      force_stray = 1'b0;

      // randomized traffic
      for (int k = 0; k < 300; k++) begin
         instr_t r;
         r = mk(2'($urandom_range(0, 3)), int'($urandom_range(0, 511)), {$urandom, $urandom},
                {$urandom, $urandom}, ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 31)),
                int'($urandom_range(0, 5)), {$urandom, $urandom});
         r.v = ($urandom_range(0, 3) != 0);
         iq.push_back(r);
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
